// File: rtl/song_sequencer.sv
// Song player: fetches packed {duration,tone} words from a synchronous ROM and
// holds each tone for duration*TICK_DIV clocks, with start/stop/pause/loop control.
module song_sequencer #(
  parameter int ADDR_W   = 8,
  parameter int DUR_W    = 4,
  parameter int TONE_W   = 4,
  parameter int TICK_DIV = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    pause,
  input  logic                    loop_en,
  input  logic [ADDR_W-1:0]       song_base,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic [DUR_W+TONE_W-1:0] mem_data,
  output logic [TONE_W-1:0]       tone_out,
  output logic                    note_change,
  output logic                    busy,
  output logic                    done
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, PLAY} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   base_q;
  logic [TONE_W-1:0]   tone_q;
  logic [DUR_W-1:0]    dur_q;
  logic [PRE_W-1:0]    pre_q;
  logic                nc_q;
  logic                busy_q;
  logic                done_q;

  logic [DUR_W-1:0]    rd_dur;
  logic [TONE_W-1:0]   rd_tone;
  logic [ADDR_W-1:0]   addr_inc_d;

  assign rd_dur     = mem_data[DUR_W+TONE_W-1:TONE_W];
  assign rd_tone    = mem_data[TONE_W-1:0];
  // Natural ADDR_W overflow gives the wrap for songs without an end marker.
  assign addr_inc_d = addr_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      base_q  <= '0;
      tone_q  <= '0;
      dur_q   <= '0;
      pre_q   <= '0;
      nc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      nc_q   <= 1'b0;
      done_q <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        tone_q  <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              base_q  <= song_base;
              addr_q  <= song_base;
              busy_q  <= 1'b1;
              state_q <= FETCH;
            end
          end
          FETCH: state_q <= LOAD;
          LOAD: begin
            // Old tone stays on tone_out through FETCH/LOAD so notes join seamlessly.
            if (rd_dur != '0) begin
              tone_q  <= rd_tone;
              nc_q    <= 1'b1;
              dur_q   <= rd_dur;
              pre_q   <= '0;
              state_q <= PLAY;
            end else if (loop_en) begin
              addr_q  <= base_q;
              state_q <= FETCH;
            end else begin
              tone_q  <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
          PLAY: begin
            if (!pause) begin
              if (pre_q == PRE_MAX) begin
                pre_q <= '0;
                dur_q <= dur_q - 1'b1;
                if (dur_q == 1) begin
                  addr_q  <= addr_inc_d;
                  state_q <= FETCH;
                end
              end else begin
                pre_q <= pre_q + 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign mem_addr    = addr_q;
  assign tone_out    = tone_q;
  assign note_change = nc_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
